glitc_intercom_rx_aligner: RTL and testbench
============================================

Name: glitc_intercom_rx_aligner

Overview:
- Downstream of the intercom differential input buffers: consumes the NBITS single-ended, fabric-sampled intercom lanes (one bit per lane per clock).
- Deserializes each lane into 8-bit words on a common frame phase.
- Trains the frame phase against a fixed training pattern by bit-slipping, then presents framed words and a lock indication to the intercom logic.

Parameters:
- NBITS, 4: number of intercom lanes.
- TRAIN_PATTERN, 8'hA5: per-lane training word. No rotation of it equals itself.
- LOCK_COUNT, 4: consecutive all-lane pattern matches needed to declare lock (1..15).

Ports:
- clk_i  input  1  fabric clock; lanes are sampled on its rising edge.
- rst_n_i  input  1  reset. Synchronous, active-low.
- in_i  input  NBITS  buffered intercom lanes.
- disable_i  input  1  forces IDLE and clears alignment.
- retrain_i  input  1  single-cycle pulse; forces LOCKED/VERIFY back to SEARCH.
- data_o  output  NBITS*8  framed words; lane i occupies bits [8i+7:8i], MSB = first bit received.
- valid_o  output  1  one-cycle strobe; data_o is valid on this cycle.
- locked_o  output  1  high in LOCKED.
- align_err_o  output  1  sticky; 8 slips occurred without a match. Cleared on entering IDLE.
- err_count_o  output  16  see Optional Feature.

Behaviour:
- Reset: state IDLE; frame counter 0; slip counter 0; data_o 0; valid_o 0; locked_o 0; align_err_o 0; err_count_o 0.
- Input stage: in_i is registered once, then shifted MSB-first into a per-lane 8-bit shift register every cycle.
- Frame counter: 3 bits, increments every cycle, wraps 7→0.
  - A boundary cycle is one where the counter is 7.
  - On a boundary, the shift register value (including the bit shifted that cycle) is the word.
  - Latency: last bit of a word on in_i → valid_o/data_o = 2 cycles.
- Slip: the frame counter holds for one cycle instead of incrementing. This delays the next boundary by one bit.
- States:
  - IDLE: entered on reset or while disable_i=1. Shifting continues; no valid_o. Clears slip counter and align_err_o. Exits to SEARCH on the first cycle with disable_i=0.
  - SEARCH: at each boundary, if all lanes equal TRAIN_PATTERN → VERIFY with match count 1. Otherwise slip once and increment the slip counter. When the slip counter would reach 8: set align_err_o, reset the slip counter to 0, stay in SEARCH.
  - VERIFY: at each boundary, an all-lane match increments the match count; reaching LOCK_COUNT → LOCKED. Any lane mismatch → SEARCH, match count 0, no slip on that boundary.
  - LOCKED: locked_o=1. valid_o pulses at every boundary with data_o updated. No slipping.
- Precedence, highest first: rst_n_i low > disable_i > retrain_i > normal transitions.
  - retrain_i in SEARCH or IDLE: ignored.
  - retrain_i coincident with the boundary that would lock: SEARCH wins.
- valid_o also pulses on boundaries in VERIFY, so the training words are visible; it does not pulse in SEARCH or IDLE.
- data_o holds its last value between strobes.

Optional Feature:
- Macro: GLITC_INTERCOM_RX_ERRCNT_EN.
- Defined: err_count_o is a 16-bit saturating counter (holds at 16'hFFFF). It increments by 1 on each VERIFY→SEARCH fall-back and each retrain_i-induced exit from LOCKED. If both occur in one cycle, it increments once. Cleared only by reset.
- Undefined: err_count_o tied to 0 and no counter logic is synthesized.

Decomposition:
- Package glitc_intercom_pkg:
  - WORD_BITS=8
  - default TRAIN_PATTERN
  - state enum {IDLE, SEARCH, VERIFY, LOCKED}
- Sub-module glitc_intercom_lane_deser: input register + 8-bit shift register + word capture register for one lane, instantiated NBITS times. It takes a shared boundary strobe from the parent FSM.

Test Plan:
- Reset, then disable_i=0 with TRAIN_PATTERN on all lanes at phase offset d=0 → no slips; locked_o rises at the 4th matching boundary (LOCK_COUNT=4); valid_o pulses every 8 cycles thereafter.
- Pattern offset d=3 bits late → exactly 3 slips, then lock after 4 further matching words; data_o = {4{8'hA5}} on the strobe before lock.
- Lane 2 carries 8'h00 while the others carry the pattern → never leaves SEARCH; align_err_o sets after the 8th slip and stays set; clearing requires disable_i=1 for ≥1 cycle.
- While LOCKED, pulse retrain_i → locked_o falls the next cycle and state is SEARCH; with the ERRCNT macro, err_count_o goes 0→1. Pulse retrain_i and disable_i together → state IDLE, err_count_o unchanged.
- In VERIFY after 2 matches, inject one corrupted word (8'hA4 on lane 0) → return to SEARCH without a slip on that boundary; relock requires 4 fresh matches; err_count_o increments by 1 with the macro, stays 0 without.
- Assert rst_n_i low for 1 cycle mid-LOCKED → all outputs 0 on the next cycle, including err_count_o; retraining proceeds normally afterwards.

Source files
------------

// File: rtl/glitc_intercom_pkg.sv
// ---------------------------------------------------------------------------
// glitc_intercom_pkg
//   Shared definitions for the intercom receive aligner: word width, the
//   default per-lane training word and the aligner state encoding.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package glitc_intercom_pkg;

  // Bits per deserialized word on each lane.
  localparam int WORD_BITS = 8;

  // Default training word. No rotation of 8'hA5 equals itself, so a match
  // can only occur at exactly one frame phase.
  localparam logic [WORD_BITS-1:0] DEFAULT_TRAIN_PATTERN = 8'hA5;

  // Alignment state machine encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/glitc_intercom_lane_deser.sv
// ---------------------------------------------------------------------------
// glitc_intercom_lane_deser
//   One intercom lane: input register, MSB-first shift register and a word
//   capture register. The parent decides where frame boundaries fall and
//   pulses i_capture on the boundaries whose word should be presented.
//
//   Ports:
//     clk_i      fabric clock, lane sampled on the rising edge
//     rst_n_i    synchronous active-low reset
//     i_bit      raw lane bit from the input buffer
//     i_capture  load the current word into the capture register
//     o_word     word formed this cycle (shift history + newest bit)
//     o_data     last captured word, MSB = first bit received
// ---------------------------------------------------------------------------
module glitc_intercom_lane_deser
  import glitc_intercom_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 i_bit,
  input  logic                 i_capture,
  output logic [WORD_BITS-1:0] o_word,
  output logic [WORD_BITS-1:0] o_data
);

  logic                 r_in;
  logic [WORD_BITS-2:0] r_shift;
  logic [WORD_BITS-1:0] r_data;
  logic [WORD_BITS-1:0] w_word;

  // The registered input bit is the eighth (newest) bit of the word, so the
  // history register only needs to hold the seven older bits.
  assign w_word = {r_shift, r_in};
  assign o_word = w_word;
  assign o_data = r_data;

  // Input register, shift history and capture register. Shifting runs every
  // cycle regardless of alignment state; only capture is gated.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_in    <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      r_in    <= i_bit;
      r_shift <= w_word[WORD_BITS-2:0];
      if (i_capture) begin
        r_data <= w_word;
      end
    end
  end

endmodule

// File: rtl/glitc_intercom_rx_aligner.sv
// ---------------------------------------------------------------------------
// glitc_intercom_rx_aligner
//   Deserializes NBITS intercom lanes into 8-bit words on a common frame
//   phase and trains that phase against TRAIN_PATTERN by bit-slipping.
//   Framed words are strobed out in VERIFY and LOCKED.
//
//   Optional build macro: GLITC_INTERCOM_RX_ERRCNT_EN
//     defined   : err_count_o counts training fall-backs (saturating)
//     undefined : err_count_o is tied to zero
//
//   Ports:
//     clk_i        fabric clock
//     rst_n_i      synchronous active-low reset
//     in_i         NBITS buffered intercom lanes
//     disable_i    forces IDLE and clears alignment status
//     retrain_i    pulse, sends VERIFY/LOCKED back to SEARCH
//     data_o       framed words, lane i at [8i+7:8i]
//     valid_o      one-cycle strobe for data_o
//     locked_o     high while LOCKED
//     align_err_o  sticky: 8 slips without a match
//     err_count_o  training error count (see macro above)
// ---------------------------------------------------------------------------
module glitc_intercom_rx_aligner
  import glitc_intercom_pkg::*;
#(
  parameter int                   NBITS         = 4,
  parameter logic [WORD_BITS-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
  parameter int                   LOCK_COUNT    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [NBITS-1:0]           in_i,
  input  logic                       disable_i,
  input  logic                       retrain_i,
  output logic [NBITS*WORD_BITS-1:0] data_o,
  output logic                       valid_o,
  output logic                       locked_o,
  output logic                       align_err_o,
  output logic [15:0]                err_count_o
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [2:0] LAST_BIT = 3'(WORD_BITS - 1);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2:0]           r_frame;
  logic                 r_hold;
  logic [2:0]           r_slip_cnt;
  logic [2:0]           w_slip_cnt_nxt;
  logic [3:0]           r_match_cnt;
  logic [3:0]           w_match_cnt_nxt;
  logic [3:0]           w_match_inc;
  logic                 r_valid;
  logic                 r_align_err;
  logic                 w_boundary;
  logic                 w_strobe;
  logic                 w_all_match;
  logic                 w_slip;
  logic                 w_set_err;
  logic                 w_clr_err;
  logic [WORD_BITS-1:0] w_lane_word [NBITS];

  assign w_boundary  = (r_frame == LAST_BIT);
  assign w_strobe    = w_boundary && ((r_state == VERIFY) || (r_state == LOCKED));
  assign w_match_inc = r_match_cnt + 4'd1;

  assign valid_o     = r_valid;
  assign locked_o    = (r_state == LOCKED);
  assign align_err_o = r_align_err;

  // One deserializer per lane, all sharing the same boundary strobe so every
  // lane is framed on the same phase.
  for (genvar g = 0; g < NBITS; g++) begin : g_lane
    glitc_intercom_lane_deser u_lane (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .i_bit     (in_i[g]),
      .i_capture (w_strobe),
      .o_word    (w_lane_word[g]),
      .o_data    (data_o[g*WORD_BITS +: WORD_BITS])
    );
  end

  // A training match needs every lane to show the pattern on the same word.
  always_comb begin
    w_all_match = 1'b1;
    for (int i = 0; i < NBITS; i++) begin
      if (w_lane_word[i] != TRAIN_PATTERN) begin
        w_all_match = 1'b0;
      end
    end
  end

  // Next-state logic. disable_i outranks retrain_i, which outranks the
  // normal boundary-driven transitions, so a retrain on the boundary that
  // would have locked still lands in SEARCH.
  always_comb begin
    w_state_nxt     = r_state;
    w_slip_cnt_nxt  = r_slip_cnt;
    w_match_cnt_nxt = r_match_cnt;
    w_slip          = 1'b0;
    w_set_err       = 1'b0;
    w_clr_err       = 1'b0;

    if (disable_i) begin
      w_state_nxt     = IDLE;
      w_slip_cnt_nxt  = '0;
      w_match_cnt_nxt = '0;
      w_clr_err       = 1'b1;
    end else if (retrain_i && ((r_state == VERIFY) || (r_state == LOCKED))) begin
      w_state_nxt     = SEARCH;
      w_match_cnt_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt    = SEARCH;
          w_slip_cnt_nxt = '0;
          w_clr_err      = 1'b1;
        end
        SEARCH: begin
          if (w_boundary) begin
            if (w_all_match) begin
              w_state_nxt     = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
              w_match_cnt_nxt = 4'd1;
              w_slip_cnt_nxt  = '0;
            end else begin
              // A full rotation of slips without a match flags an error and
              // starts the rotation count over.
              w_slip = 1'b1;
              if (r_slip_cnt == 3'd7) begin
                w_slip_cnt_nxt = '0;
                w_set_err      = 1'b1;
              end else begin
                w_slip_cnt_nxt = r_slip_cnt + 3'd1;
              end
            end
          end
        end
        VERIFY: begin
          if (w_boundary) begin
            if (w_all_match) begin
              w_match_cnt_nxt = w_match_inc;
              if (w_match_inc >= LOCK_CNT) begin
                w_state_nxt = LOCKED;
              end
            end else begin
              // Phase was already found once; go back to searching without
              // disturbing it.
              w_state_nxt     = SEARCH;
              w_match_cnt_nxt = '0;
            end
          end
        end
        LOCKED: begin
          w_state_nxt = LOCKED;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, training counters, strobe and sticky alignment error.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_slip_cnt  <= '0;
      r_match_cnt <= '0;
      r_valid     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slip_cnt  <= w_slip_cnt_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_valid     <= w_strobe;
      if (w_clr_err) begin
        r_align_err <= 1'b0;
      end else if (w_set_err) begin
        r_align_err <= 1'b1;
      end
    end
  end

  // Frame counter. A slip is decided on a boundary (counter = 7), so the
  // counter wraps to 0 as usual and then holds at 0 for one extra cycle;
  // that pushes the next boundary one bit later.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_frame <= '0;
      r_hold  <= 1'b0;
    end else if (w_slip) begin
      r_frame <= r_frame + 3'd1;
      r_hold  <= 1'b1;
    end else if (r_hold) begin
      r_hold  <= 1'b0;
    end else begin
      r_frame <= r_frame + 3'd1;
    end
  end

`ifdef GLITC_INTERCOM_RX_ERRCNT_EN
  logic [15:0] r_err_cnt;
  logic        w_err_event;

  // One event per cycle at most: a VERIFY mismatch fall-back or a retrain
  // out of LOCKED. A simultaneous disable_i is a shutdown, not an error.
  assign w_err_event = !disable_i &&
                       (((r_state == LOCKED) && retrain_i) ||
                        ((r_state == VERIFY) && w_boundary && !w_all_match));

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_err_cnt <= '0;
    end else if (w_err_event && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count_o = r_err_cnt;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_glitc_intercom_rx_aligner.sv
// ---------------------------------------------------------------------------
// tb_glitc_intercom_rx_aligner
//   Randomized bench for glitc_intercom_rx_aligner. A behavioural model
//   tracks where frame boundaries fall in absolute clock-edge time and
//   applies the training rules to the words the lanes carried; expected
//   strobes and per-cycle status are queued and a separate monitor compares
//   them with the DUT. Honours GLITC_INTERCOM_RX_ERRCNT_EN.
// ---------------------------------------------------------------------------
module tb_glitc_intercom_rx_aligner;

  localparam int         NB    = 4;
  localparam logic [7:0] TP    = 8'hA5;
  localparam int         LOCKN = 4;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_VERIFY = 2;
  localparam int M_LOCKED = 3;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic [NB-1:0]   inBits = '0;
  logic            dis = 1'b0;
  logic            ret = 1'b0;
  logic [NB*8-1:0] dataO;
  logic            validO;
  logic            lockedO;
  logic            alignErrO;
  logic [15:0]     errCntO;

  glitc_intercom_rx_aligner #(
    .NBITS         (NB),
    .TRAIN_PATTERN (TP),
    .LOCK_COUNT    (LOCKN)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .in_i        (inBits),
    .disable_i   (dis),
    .retrain_i   (ret),
    .data_o      (dataO),
    .valid_o     (validO),
    .locked_o    (lockedO),
    .align_err_o (alignErrO),
    .err_count_o (errCntO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          edgeNo;
    logic        valid;
    logic [31:0] data;
    logic        locked;
    logic        alignErr;
    logic [15:0] errCnt;
  } status_t;

  typedef struct {
    int          edgeNo;
    logic [31:0] data;
  } strobe_t;

  status_t stQ[$];
  strobe_t dQ[$];

  int checks    = 0;
  int passes    = 0;
  int edgeCount = 0;

  // Reference model state: boundaries are absolute edge numbers, history is
  // the last eight sampled lane vectors (index 0 oldest).
  int          mState   = M_IDLE;
  int          mMatches = 0;
  int          mSlips   = 0;
  int          mNextB   = 8;
  logic        mAlignErr = 1'b0;
  logic [15:0] mErrCnt  = '0;
  logic [31:0] mData    = '0;
  logic [NB-1:0] mHist [8];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
                  name, edgeCount, actual, expected);
  endtask

  function automatic logic [7:0] laneWord(input int lane);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[7-k] = mHist[k][lane];
    return w;
  endfunction

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic modelStep(input logic [NB-1:0] b, input logic d,
                           input logic r, input logic rn);
    status_t     s;
    strobe_t     st;
    logic        boundary;
    logic        allMatch;
    logic        slip;
    logic [7:0]  w;
    logic [31:0] words;
    edgeCount++;
    s.valid = 1'b0;
    if (!rn) begin
      mState = M_IDLE; mMatches = 0; mSlips = 0;
      mAlignErr = 1'b0; mErrCnt = '0; mData = '0;
      mNextB = edgeCount + 8;
      for (int k = 0; k < 8; k++) mHist[k] = '0;
    end else begin
      boundary = (edgeCount == mNextB);
      allMatch = 1'b1;
      words = '0;
      for (int l = 0; l < NB; l++) begin
        w = laneWord(l);
        words[8*l +: 8] = w;
        if (w != TP) allMatch = 1'b0;
      end
      slip = 1'b0;
      if (boundary && (mState == M_VERIFY || mState == M_LOCKED)) begin
        s.valid   = 1'b1;
        mData     = words;
        st.edgeNo = edgeCount;
        st.data   = words;
        dQ.push_back(st);
      end
`ifdef GLITC_INTERCOM_RX_ERRCNT_EN
      if (!d && ((mState == M_LOCKED && r) ||
                 (mState == M_VERIFY && boundary && !allMatch)) &&
          mErrCnt != 16'hFFFF)
        mErrCnt = mErrCnt + 16'd1;
`endif
      if (d) begin
        mState = M_IDLE; mMatches = 0; mSlips = 0; mAlignErr = 1'b0;
      end else if (r && (mState == M_VERIFY || mState == M_LOCKED)) begin
        mState = M_SEARCH; mMatches = 0;
      end else if (mState == M_IDLE) begin
        mState = M_SEARCH; mSlips = 0; mAlignErr = 1'b0;
      end else if (mState == M_SEARCH && boundary) begin
        if (allMatch) begin
          mState = (LOCKN <= 1) ? M_LOCKED : M_VERIFY;
          mMatches = 1; mSlips = 0;
        end else begin
          slip = 1'b1;
          mSlips++;
          if (mSlips == 8) begin mAlignErr = 1'b1; mSlips = 0; end
        end
      end else if (mState == M_VERIFY && boundary) begin
        if (allMatch) begin
          mMatches++;
          if (mMatches >= LOCKN) mState = M_LOCKED;
        end else begin
          mState = M_SEARCH; mMatches = 0;
        end
      end
      if (boundary) mNextB = edgeCount + (slip ? 9 : 8);
      for (int k = 0; k < 7; k++) mHist[k] = mHist[k+1];
      mHist[7] = b;
    end
    s.edgeNo   = edgeCount;
    s.data     = mData;
    s.locked   = (mState == M_LOCKED);
    s.alignErr = mAlignErr;
    s.errCnt   = mErrCnt;
    stQ.push_back(s);
  endtask

  task automatic applyStimulus(input logic [NB-1:0] b, input logic d,
                               input logic r, input logic rn);
    @(negedge clk);
    inBits = b; dis = d; ret = r; rstN = rn;
    @(posedge clk);
    modelStep(b, d, r, rn);
  endtask

  // Training stream: every lane carries the pattern, offset by sh bits.
  // lane2Zero forces lane 2 low; flipPct corrupts lane 0's word LSB (A5->A4).
  function automatic logic [NB-1:0] makeBits(input int sh, input bit lane2Zero,
                                             input int flipPct);
    logic [7:0]    tpv;
    logic [NB-1:0] b;
    int            pos;
    tpv = TP;
    pos = (edgeCount + 1 + sh) % 8;
    b = {NB{tpv[7-pos]}};
    if (lane2Zero) b[2] = 1'b0;
    if (pos == 7 && flipPct > 0 && $urandom_range(0, 99) < flipPct) b[0] = ~b[0];
    return b;
  endfunction

  task automatic runPhase(input int cycles, input int sh, input bit lane2Zero,
                          input int flipPct, input int retPct, input int disPct);
    logic r;
    logic d;
    for (int i = 0; i < cycles; i++) begin
      r = (retPct > 0) && ($urandom_range(0, 99) < retPct) && (mState != M_VERIFY);
      d = (disPct > 0) && ($urandom_range(0, 99) < disPct);
      applyStimulus(makeBits(sh, lane2Zero, flipPct), d, r, 1'b1);
    end
  endtask

  // Monitor: per-cycle status from one queue, strobed words from the other.
  initial begin
    status_t s;
    strobe_t st;
    forever begin
      @(negedge clk);
      if (stQ.size() > 0) begin
        s = stQ.pop_front();
        checkOutput("valid_o",     64'(validO),    64'(s.valid));
        checkOutput("data_o",      64'(dataO),     64'(s.data));
        checkOutput("locked_o",    64'(lockedO),   64'(s.locked));
        checkOutput("align_err_o", 64'(alignErrO), 64'(s.alignErr));
        checkOutput("err_count_o", 64'(errCntO),   64'(s.errCnt));
      end
      if (validO === 1'b1) begin
        if (dQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_strobe at edge %0d: got valid_o=1, expected no strobe",
                   edgeCount);
        end else begin
          st = dQ.pop_front();
          checkOutput("strobe_edge", 64'(edgeCount), 64'(st.edgeNo));
          checkOutput("strobe_data", 64'(dataO),     64'(st.data));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 8; k++) mHist[k] = '0;

    $display("[TB] reset, aligned training stream");
    repeat (3) applyStimulus(makeBits(0, 0, 0), 1'b0, 1'b0, 1'b0);
    runPhase(100, 0, 0, 0, 0, 0);

    $display("[TB] reset, stream offset by 3 bits");
    applyStimulus(makeBits(3, 0, 0), 1'b0, 1'b0, 1'b0);
    runPhase(120, 3, 0, 0, 0, 0);

    $display("[TB] lane 2 stuck low, then disable to clear");
    applyStimulus(makeBits(5, 1, 0), 1'b0, 1'b0, 1'b0);
    runPhase(110, 5, 1, 0, 0, 0);
    repeat (2) applyStimulus(makeBits(5, 0, 0), 1'b1, 1'b0, 1'b1);
    runPhase(80, 5, 0, 0, 0, 0);

    $display("[TB] retrain pulses while locked");
    applyStimulus(makeBits(5, 0, 0), 1'b0, (mState != M_VERIFY), 1'b1);
    runPhase(80, 5, 0, 0, 0, 0);
    applyStimulus(makeBits(5, 0, 0), 1'b1, (mState != M_VERIFY), 1'b1);
    runPhase(80, 5, 0, 0, 0, 0);

    $display("[TB] corrupted training words on lane 0");
    applyStimulus(makeBits(2, 0, 0), 1'b0, (mState != M_VERIFY), 1'b1);
    runPhase(600, 2, 0, 30, 2, 0);

    $display("[TB] single-cycle reset while locked");
    applyStimulus(makeBits(2, 0, 0), 1'b0, 1'b0, 1'b0);
    runPhase(100, 2, 0, 0, 0, 0);

    $display("[TB] random phase changes with disable and retrain");
    for (int j = 0; j < 4; j++) runPhase(120, int'($urandom_range(0, 7)), 0, 10, 2, 1);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("strobe_queue_drained", 64'(dQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
